jk_bank_arbiter: RTL and testbench

//  Round-robin arbiter and sequencer for a WIDTH-bit bank of JK flip-flop cells.
//  Two requesters each submit a JK command (hold/reset/set/toggle) with a per-bit mask.
//  One command is granted at a time, applied to the masked bits, and completion is signalled.
//  The bank state is exported as q/qb; this is the single owner of the bank's j/k inputs.

---
 rtl/jk_bank_arbiter.sv | 152 +++++++++++++++
 tb/tb_jk_bank_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter/sequencer owning the j/k inputs of a WIDTH-bit JK cell bank.
// Optional JK_REPEAT_EN: adds rpt0/rpt1 so one grant applies its op rpt+1 times.
module jk_bank_arbiter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic [1:0]       op0,
    input  logic [WIDTH-1:0] mask0,
    input  logic             req1,
    input  logic [1:0]       op1,
    input  logic [WIDTH-1:0] mask1,
`ifdef JK_REPEAT_EN
    input  logic [3:0]       rpt0,
    input  logic [3:0]       rpt1,
`endif
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_APPLY = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             rr_q, rr_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             win1;
    logic [WIDTH-1:0] j_vec, k_vec, q_jk;

`ifdef JK_REPEAT_EN
    localparam int unsigned RPT_W = 4;
    logic [RPT_W-1:0] rpt_q, rpt_d;
`endif

    // rr_q=1 means requester 1 has priority on a tie
    assign win1 = req1 & (~req0 | rr_q);

    // JK characteristic equation applied to the latched command
    assign j_vec = mask_q & {WIDTH{op_q[1]}};
    assign k_vec = mask_q & {WIDTH{op_q[0]}};
    assign q_jk  = (j_vec & ~q_q) | (~k_vec & q_q);

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        op_d    = op_q;
        mask_d  = mask_q;
        q_d     = q_q;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
`ifdef JK_REPEAT_EN
        rpt_d   = rpt_q;
`endif
        case (state_q)
            S_IDLE: begin
                // Command is captured on the edge that enters GRANT, while req is still held
                if (req0 | req1) begin
                    state_d = S_GRANT;
                    busy_d  = 1'b1;
                    gnt0_d  = ~win1;
                    gnt1_d  = win1;
                    rr_d    = ~win1;
                    op_d    = win1 ? op1 : op0;
                    mask_d  = win1 ? mask1 : mask0;
`ifdef JK_REPEAT_EN
                    rpt_d   = win1 ? rpt1 : rpt0;
`endif
                end
            end
            S_GRANT: begin
                state_d = S_APPLY;
                busy_d  = 1'b1;
            end
            S_APPLY: begin
                q_d    = q_jk;
                busy_d = 1'b1;
`ifdef JK_REPEAT_EN
                if (rpt_q == RPT_W'(0)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    rpt_d = rpt_q - RPT_W'(1);
                end
`else
                state_d = S_DONE;
                done_d  = 1'b1;
`endif
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            rr_q    <= 1'b0;
            op_q    <= 2'b00;
            mask_q  <= '0;
            q_q     <= '0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef JK_REPEAT_EN
            rpt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            op_q    <= op_d;
            mask_q  <= mask_d;
            q_q     <= q_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef JK_REPEAT_EN
            rpt_q   <= rpt_d;
`endif
        end
    end

    assign gnt0 = gnt0_q;
    assign gnt1 = gnt1_q;
    assign busy = busy_q;
    assign done = done_q;
    assign q    = q_q;
    assign qb   = ~q_q;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Scoreboard bench for jk_bank_arbiter: driver predicts grant order and bank value,
// a negedge monitor compares every grant/done the DUT presents.
module tb_jk_bank_arbiter;

    logic       clk;
    logic       reset;
    logic       req0, req1;
    logic [1:0] op0, op1;
    logic [7:0] mask0, mask1;
`ifdef JK_REPEAT_EN
    logic [3:0] rpt0, rpt1;
`endif
    logic       gnt0, gnt1, busy, done;
    logic [7:0] q, qb;

    jk_bank_arbiter #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .req0  (req0),
        .op0   (op0),
        .mask0 (mask0),
        .req1  (req1),
        .op1   (op1),
        .mask1 (mask1),
`ifdef JK_REPEAT_EN
        .rpt0  (rpt0),
        .rpt1  (rpt1),
`endif
        .gnt0  (gnt0),
        .gnt1  (gnt1),
        .busy  (busy),
        .done  (done),
        .q     (q),
        .qb    (qb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned errors = 0;
    int unsigned checks = 0;

    // Reference state: bank value and which requester wins the next tie
    logic [7:0] q_model = 8'h00;
    bit         ptr = 1'b0;
    bit         exp_gnt[$];
    logic [7:0] exp_q[$];

    bit          mon_en = 1'b0;
    int unsigned cyc = 0;
    int unsigned gcyc = 0;
    int unsigned last_g = 0;
    bit          have_last = 1'b0;
    bit          open_txn = 1'b0;

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
        end
    endfunction

    function automatic logic [7:0] model_apply(input logic [7:0] cur, input logic [1:0] op, input logic [7:0] m);
        case (op)
            2'b01:   return cur & ~m;
            2'b10:   return cur | m;
            2'b11:   return cur ^ m;
            default: return cur;
        endcase
    endfunction

    function automatic void push_exp(input bit id, input logic [1:0] op, input logic [7:0] m);
        q_model = model_apply(q_model, op, m);
        exp_gnt.push_back(id);
        exp_q.push_back(q_model);
        ptr = ~id;
    endfunction

    // Monitor: compares grants, done values, latencies and busy window
    always @(negedge clk) begin
        cyc++;
        if (mon_en) begin
            chk("qb_complement", {24'h0, qb}, {24'h0, ~q});
            if (gnt0 || gnt1) begin
                if (exp_gnt.size() == 0) begin
                    chk("unexpected_gnt", {30'h0, gnt1, gnt0}, 32'h0);
                end else begin
                    chk("gnt_id", {30'h0, gnt1, gnt0}, exp_gnt[0] ? 32'h2 : 32'h1);
                    void'(exp_gnt.pop_front());
                end
                if (have_last)
                    chk("gnt_spacing_ge4", {31'h0, (cyc - last_g) >= 4}, 32'h1);
                last_g    = cyc;
                gcyc      = cyc;
                have_last = 1'b1;
                open_txn  = 1'b1;
            end
            chk("busy_window", {31'h0, busy}, {31'h0, open_txn});
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", {31'h0, done}, 32'h0);
                end else begin
                    chk("done_q", {24'h0, q}, {24'h0, exp_q[0]});
                    void'(exp_q.pop_front());
                end
                chk("done_latency", cyc - gcyc, 32'd2);
                open_txn = 1'b0;
            end
        end
    end

    // Issue one round of requests from idle; holds each req until its grant
    task automatic do_round(input bit r0, input logic [1:0] o0, input logic [7:0] m0,
                            input bit r1, input logic [1:0] o1, input logic [7:0] m1);
        bit p0, p1, s0, s1;
        int c;
        if (r0 && r1) begin
            if (ptr) begin
                push_exp(1'b1, o1, m1);
                push_exp(1'b0, o0, m0);
            end else begin
                push_exp(1'b0, o0, m0);
                push_exp(1'b1, o1, m1);
            end
        end else if (r0) begin
            push_exp(1'b0, o0, m0);
        end else begin
            push_exp(1'b1, o1, m1);
        end
        req0 = r0; op0 = o0; mask0 = m0;
        req1 = r1; op1 = o1; mask1 = m1;
        p0 = r0; p1 = r1; s0 = 1'b0; s1 = 1'b0;
        c = 0;
        while ((p0 || p1 || s0 || s1) && c < 40) begin
            @(negedge clk);
            c++;
            // Scrambling after the grant must not affect the accepted command
            if (s0) begin op0 = 2'($urandom_range(3, 0)); mask0 = 8'($urandom); s0 = 1'b0; end
            if (s1) begin op1 = 2'($urandom_range(3, 0)); mask1 = 8'($urandom); s1 = 1'b0; end
            if (p0 && gnt0) begin req0 = 1'b0; p0 = 1'b0; s0 = 1'b1; end
            if (p1 && gnt1) begin req1 = 1'b0; p1 = 1'b0; s1 = 1'b1; end
        end
        if (p0 || p1) chk("grant_timeout", {30'h0, p1, p0}, 32'h0);
        c = 0;
        while ((exp_q.size() != 0 || busy) && c < 20) begin
            @(negedge clk);
            c++;
        end
        if (exp_q.size() != 0) chk("done_timeout", exp_q.size(), 32'h0);
    endtask

    initial begin
        bit r0, r1;
        int sel;
        reset = 1'b1;
        req0 = 1'b0; op0 = 2'b00; mask0 = 8'h00;
        req1 = 1'b0; op1 = 2'b00; mask1 = 8'h00;
`ifdef JK_REPEAT_EN
        rpt0 = 4'd0; rpt1 = 4'd0;
`endif
        // Asynchronous reset asserted mid-cycle
        @(posedge clk); @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk("rst_q", {24'h0, q}, 32'h00);
        chk("rst_qb", {24'h0, qb}, 32'hFF);
        chk("rst_ctl", {28'h0, gnt0, gnt1, busy, done}, 32'h0);
        @(negedge clk);
        reset  = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);

        // Directed command sequence
        do_round(1'b1, 2'b10, 8'h0F, 1'b0, 2'b00, 8'h00);
        do_round(1'b1, 2'b01, 8'hFF, 1'b0, 2'b00, 8'h00);
        do_round(1'b0, 2'b00, 8'h00, 1'b1, 2'b10, 8'hA5);
        do_round(1'b1, 2'b11, 8'hFF, 1'b0, 2'b00, 8'h00);
        do_round(1'b0, 2'b00, 8'h00, 1'b1, 2'b01, 8'hF0);
        do_round(1'b1, 2'b00, 8'hFF, 1'b0, 2'b00, 8'h00);
        do_round(1'b1, 2'b11, 8'h00, 1'b0, 2'b00, 8'h00);

        // Ties: both requesters together
        for (int i = 0; i < 4; i++)
            do_round(1'b1, 2'b11, 8'(1 << i), 1'b1, 2'b10, 8'(8'h80 >> i));

        // Random rounds
        for (int i = 0; i < 40; i++) begin
            sel = int'($urandom_range(3, 1));
            r0  = (sel & 1) != 0;
            r1  = (sel & 2) != 0;
            do_round(r0, 2'($urandom_range(3, 0)), 8'($urandom),
                     r1, 2'($urandom_range(3, 0)), 8'($urandom));
        end
        do_round(1'b1, 2'b10, 8'hFF, 1'b0, 2'b00, 8'h00);

        // Reset during APPLY aborts; a held req is re-granted after release
        mon_en = 1'b0;
        req0 = 1'b1; op0 = 2'b11; mask0 = 8'hFF;
        @(negedge clk);
        chk("abort_gnt0", {31'h0, gnt0}, 32'h1);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("abort_q", {24'h0, q}, 32'h00);
        chk("abort_qb", {24'h0, qb}, 32'hFF);
        chk("abort_ctl", {28'h0, gnt0, gnt1, busy, done}, 32'h0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("abort_no_done", {31'h0, done}, 32'h0);
        end
        reset = 1'b1;
        @(negedge clk);
        chk("regrant_gnt0", {30'h0, gnt1, gnt0}, 32'h1);
        req0 = 1'b0;
        @(negedge clk);
        chk("regrant_busy", {31'h0, busy}, 32'h1);
        @(negedge clk);
        chk("regrant_done", {31'h0, done}, 32'h1);
        chk("regrant_q", {24'h0, q}, 32'hFF);
        chk("regrant_qb", {24'h0, qb}, 32'h00);
        @(negedge clk);
        chk("regrant_idle", {30'h0, busy, done}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
